left_shift_seq: RTL

//  Multi-cycle left shifter/rotator; the left-direction companion to the datapath's registered

---
 rtl/left_shift_seq_pkg.sv | 14 +
 rtl/left_shift_seq.sv | 85 ++++++++
 2 files changed

// File: rtl/left_shift_seq_pkg.sv
// Shared encodings for the sequential shifters: FSM state codes and shift-mode values.
// The right-shift twin and the ALU decode against the same codes.
package left_shift_seq_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic ModeLsl = 1'b0;
    localparam logic ModeRol = 1'b1;

endpackage

// File: rtl/left_shift_seq.sv
// Multi-cycle left shifter/rotator, one bit per clock under a start/busy/done handshake.
// Reports carry-out and signed overflow (logical mode) for multiply-by-2^n and normalisation.
module left_shift_seq
    import left_shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   shift,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic             carry_out,
    output logic             ovf
);

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [SHW-1:0]   cnt_q;
    logic             mode_q;
    logic             ovf_acc_q;
    logic             co_acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            work_q    <= '0;
            cnt_q     <= '0;
            mode_q    <= ModeLsl;
            ovf_acc_q <= 1'b0;
            co_acc_q  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            R         <= '0;
            carry_out <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        work_q    <= A;
                        cnt_q     <= shift;
                        mode_q    <= mode;
                        ovf_acc_q <= 1'b0;
                        co_acc_q  <= 1'b0;
                        busy      <= 1'b1;
                        state_q   <= (shift != '0) ? StShift : StDone;
                    end
                end
                StShift: begin
                    co_acc_q <= work_q[WIDTH-1];
                    // A sign change at any step means the value left the signed range.
                    if (mode_q == ModeLsl) begin
                        ovf_acc_q <= ovf_acc_q | (work_q[WIDTH-1] ^ work_q[WIDTH-2]);
                    end
                    work_q <= {work_q[WIDTH-2:0],
                               (mode_q == ModeRol) ? work_q[WIDTH-1] : 1'b0};
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done      <= 1'b1;
                    R         <= work_q;
                    carry_out <= co_acc_q;
                    ovf       <= ovf_acc_q & ~mode_q;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
